cache_bist: RTL
===============

CACHE_BIST -- requirements
Module: cache_bist

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, byte address of first tested word (4-byte aligned).
REQ-002 SHALL have parameter WORD_COUNT, default 64, number of 32-bit words tested (1..65535).
REQ-003 SHALL have parameter SEED, default 32'h5A5A_C3C3, pattern seed.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait per request.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  pulse: begin a test run.
REQ-008 SHALL have port address  output  32  cache request byte address.
REQ-009 SHALL have port data_in  output  32  write data to cache.
REQ-010 SHALL have port write_enable  output  4  byte-lane write strobes; 0 means read.
REQ-011 SHALL have port data_out  input  32  read data from cache.
REQ-012 SHALL have port data_out_ready  input  1  data_out valid.
REQ-013 SHALL have port busy  input  1  cache servicing miss/eviction.
REQ-014 SHALL have ports done  output  1 (run finished), pass  output  1 (no errors, no timeout), timeout  output  1 (a wait exceeded TIMEOUT_CYCLES).
REQ-015 SHALL have ports error_count  output  16 (saturating mismatch count), fail_address  output  32 and fail_data  output  32 (first mismatch address and read value).

Function
REQ-016 SHALL define pattern P(a) = {a[15:0], ~a[15:0]} ^ SEED for byte address a.
REQ-017 SHALL define merged value M(a) = P(a) with byte lane k = (a>>2) mod 4 replaced by 8'hA5.
REQ-018 SHALL run four phases in order, each over words a = BASE_ADDRESS + 4*i, i = 0..WORD_COUNT-1: W1 full-word write P(a) (write_enable 4'b1111); R1 read, expect P(a); W2 byte write, data_in = {4{8'hA5}}, write_enable = 1<<k; R2 read, expect M(a).
REQ-019 SHALL use states IDLE, ISSUE, WAIT, NEXT, DONE; IDLE->ISSUE on start; ISSUE->WAIT after one cycle; WAIT->NEXT on completion; NEXT->ISSUE (next word or phase) or DONE after last R2 word; DONE->ISSUE on start.
REQ-020 SHALL hold address, data_in, write_enable stable from ISSUE through the completion cycle.
REQ-021 SHALL treat a write complete in the first WAIT cycle with busy low; a read complete in the first WAIT cycle with data_out_ready high and busy low, sampling data_out that cycle.
REQ-022 SHALL drive write_enable = 0 in NEXT, IDLE and DONE.
REQ-023 SHALL, on read mismatch, increment error_count (saturate at 16'hFFFF) and latch fail_address/fail_data only if error_count was 0.
REQ-024 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES set timeout=1 and go to DONE, abandoning the run.
REQ-025 SHALL in DONE assert done=1 and pass = (error_count==0 && !timeout); both held until next start.
REQ-026 SHALL ignore start outside IDLE and DONE.
REQ-027 SHALL on start clear done, pass, timeout, error_count, fail_address, fail_data in the same edge it enters ISSUE.
REQ-028 SHALL with WORD_COUNT larger than cache capacity exercise evictions; correctness relies only on the busy/data_out_ready handshake.

Reset
REQ-029 SHALL on rst force IDLE and address=0, data_in=0, write_enable=0, done=0, pass=0, timeout=0, error_count=0, fail_address=0, fail_data=0, wait counter 0.
REQ-030 SHALL on rst mid-run abandon the request immediately; write_enable=0 the cycle after the rst edge; no further requests until start.

Verification
REQ-031 SHALL cover: start with Cache (1-bit line index) + BurstRAM, defaults -> done=1, pass=1, error_count=0, timeout=0; every word at 0..252 reads M(a) via a follow-up cache read.
REQ-032 SHALL cover: bench flips bit 0 of data_out on R1 read of address 8 -> done=1, pass=0, error_count=1, fail_address=8, fail_data=P(8)^1.
REQ-033 SHALL cover: behavioural cache holding busy=1 forever after first ISSUE -> timeout=1, done=1, pass=0 exactly TIMEOUT_CYCLES WAIT cycles later.
REQ-034 SHALL cover: rst pulse during R1 at word 10 -> all outputs at reset values next cycle, write_enable=0; later start completes with pass=1.
REQ-035 SHALL cover: start pulses during run ignored (run count unchanged); second start after DONE repeats run, pass=1.
REQ-036 SHALL cover: WORD_COUNT=1, BASE_ADDRESS=64 -> exactly four requests (writes 4'b1111, then 4'b0001), final read expects {P(64)[31:8], 8'hA5}.

Source files
------------

// File: rtl/cache_bist.sv
// cache_bist: built-in self test for a 32-bit word cache.
//
// The test runs four passes over WORD_COUNT words starting at BASE_ADDRESS:
//   W1: full-word write of P(a)
//   R1: read back and expect P(a)
//   W2: single-byte write of 8'hA5 into lane (a>>2) mod 4
//   R2: read back and expect the merged word M(a)
// Here P(a) = {a[15:0], ~a[15:0]} ^ SEED.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   start                        pulse that begins a run (only honoured when idle or done)
//   address, data_in             request address and write data
//   write_enable                 byte-lane strobes; all zero means read
//   data_out, data_out_ready     read data from the cache and its valid flag
//   busy                         cache is servicing a miss or eviction
//   done, pass, timeout          run status, held until the next start
//   error_count                  saturating count of read mismatches
//   fail_address, fail_data      address and read value of the first mismatch
module cache_bist #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int unsigned WORD_COUNT     = 64,
  parameter logic [31:0] SEED           = 32'h5A5A_C3C3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [3:0]  write_enable,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [31:0] fail_address,
  output logic [31:0] fail_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
  typedef enum logic [2:0] {PH_W1, PH_R1, PH_W2, PH_R2, PH_END} phase_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES);
  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [15:0]   idx_q, idx_d;
  logic [31:0]   address_q, address_d;
  logic [31:0]   data_in_q, data_in_d;
  logic [3:0]    we_q, we_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   error_count_q, error_count_d;
  logic [31:0]   fail_address_q, fail_address_d;
  logic [31:0]   fail_data_q, fail_data_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  phase_t      ld_phase;
  logic [15:0] ld_idx;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_we;

  logic        is_read;
  logic        req_done;
  logic        mismatch;
  logic [31:0] expected;

  function automatic logic [31:0] pattern_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ SEED;
  endfunction

  function automatic logic [31:0] merged_of(input logic [31:0] a);
    logic [31:0] v;
    v = pattern_of(a);
    v[{a[3:2], 3'b000} +: 8] = 8'hA5;
    return v;
  endfunction

  // Request to load on entry to ISSUE: the first W1 word when starting,
  // otherwise the phase/word already advanced when the previous request completed.
  always_comb begin
    ld_phase = (state_q == NEXT) ? phase_q : PH_W1;
    ld_idx   = (state_q == NEXT) ? idx_q : 16'd0;
    ld_addr  = BASE_ADDRESS + {14'd0, ld_idx, 2'b00};
    ld_data  = pattern_of(ld_addr);
    ld_we    = 4'b0000;
    case (ld_phase)
      PH_W1:   ld_we = 4'b1111;
      PH_W2: begin
        ld_data = {4{8'hA5}};
        ld_we   = 4'b0001 << ld_addr[3:2];
      end
      default: ;
    endcase
  end

  // Sequencer: request handshake, word/phase advance, result bookkeeping.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    idx_d          = idx_q;
    address_d      = address_q;
    data_in_d      = data_in_q;
    we_d           = we_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    error_count_d  = error_count_q;
    fail_address_d = fail_address_q;
    fail_data_d    = fail_data_q;
    wait_cnt_d     = wait_cnt_q;

    is_read  = (we_q == 4'b0000);
    expected = (phase_q == PH_R1) ? pattern_of(address_q) : merged_of(address_q);
    req_done = !busy && (!is_read || data_out_ready);
    mismatch = is_read && (data_out != expected);

    case (state_q)
      IDLE, DONE: begin
        we_d = 4'b0000;
        if (start) begin
          state_d        = ISSUE;
          phase_d        = PH_W1;
          idx_d          = 16'd0;
          address_d      = ld_addr;
          data_in_d      = ld_data;
          we_d           = ld_we;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          timeout_d      = 1'b0;
          error_count_d  = 16'd0;
          fail_address_d = 32'd0;
          fail_data_d    = 32'd0;
          wait_cnt_d     = '0;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (req_done) begin
          state_d = NEXT;
          we_d    = 4'b0000;
          if (mismatch) begin
            if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
            if (error_count_q == 16'd0) begin
              fail_address_d = address_q;
              fail_data_d    = data_out;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = 16'd0;
            phase_d = phase_t'(phase_q + 3'd1);
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else if (wait_cnt_q + CW'(1) == TIMEOUT_LIM) begin
          // The cache never answered: abandon the whole run.
          state_d   = DONE;
          we_d      = 4'b0000;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      NEXT: begin
        if (phase_q == PH_END) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (error_count_q == 16'd0) && !timeout_q;
        end else begin
          state_d   = ISSUE;
          address_d = ld_addr;
          data_in_d = ld_data;
          we_d      = ld_we;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= PH_W1;
      idx_q          <= 16'd0;
      address_q      <= 32'd0;
      data_in_q      <= 32'd0;
      we_q           <= 4'b0000;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      error_count_q  <= 16'd0;
      fail_address_q <= 32'd0;
      fail_data_q    <= 32'd0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      idx_q          <= idx_d;
      address_q      <= address_d;
      data_in_q      <= data_in_d;
      we_q           <= we_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      error_count_q  <= error_count_d;
      fail_address_q <= fail_address_d;
      fail_data_q    <= fail_data_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign address      = address_q;
  assign data_in      = data_in_q;
  assign write_enable = we_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign error_count  = error_count_q;
  assign fail_address = fail_address_q;
  assign fail_data    = fail_data_q;

endmodule
